psc_tile_loader: RTL



---
 rtl/psc_pkg.sv | 21 ++
 rtl/psc_row_bank.sv | 60 ++++++
 rtl/psc_tile_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/psc_pkg.sv
// Shared definitions for the parallel-serial converter tile loader:
// drain FSM state encoding, converter mode encodings and row sizing.
package psc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } psc_state_t;

  localparam int PSC_MODE_W = 2;
  localparam logic [PSC_MODE_W-1:0] PSC_MODE_0 = 2'd0;
  localparam logic [PSC_MODE_W-1:0] PSC_MODE_1 = 2'd1;
  localparam logic [PSC_MODE_W-1:0] PSC_MODE_2 = 2'd2;
  localparam logic [PSC_MODE_W-1:0] PSC_MODE_3 = 2'd3;

  // Words packed into one tile row: PE words for each converter block.
  function automatic int row_words(input int pe, input int tile_dim);
    return pe * tile_dim;
  endfunction

endpackage

// File: rtl/psc_row_bank.sv
// One row bank: word storage, write index, zero-fill on flush and a full flag.
// fill_done is high in the cycle the bank becomes full, so the parent can
// advance its fill pointer on the same edge.
module psc_row_bank #(
  parameter int WORD_W = 16,
  parameter int N      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic                flush,
  input  logic                clear,
  output logic [N*WORD_W-1:0] data,
  output logic                full,
  output logic                fill_done
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [IDX_W-1:0] wr_idx;
  logic             last_word;
  logic             flush_eff;

  // A flush counts only when the bank holds at least one word after this
  // cycle's write and that write did not already complete the row.
  always_comb begin
    last_word = wr_en && (wr_idx == LAST_IDX);
    flush_eff = flush && !last_word && (wr_en || (wr_idx != '0));
    fill_done = last_word || flush_eff;
  end

  // Word storage, write index and full flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data   <= '0;
      full   <= 1'b0;
      wr_idx <= '0;
    end else begin
      if (clear) begin
        full <= 1'b0;
      end
      if (fill_done) begin
        full   <= 1'b1;
        wr_idx <= '0;
      end else if (wr_en) begin
        wr_idx <= wr_idx + 1'b1;
      end
      for (int k = 0; k < N; k++) begin
        if (wr_en && (wr_idx == IDX_W'(k))) begin
          data[k*WORD_W +: WORD_W] <= wr_data;
        end else if (flush_eff && (wr_idx <= IDX_W'(k))) begin
          data[k*WORD_W +: WORD_W] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/psc_tile_loader.sv
// Double-buffered tile row loader feeding the parallel-serial converter array.
// Optional feature: define PSC_LOADER_PERF_EN to add perf_launch_count.
module psc_tile_loader
  import psc_pkg::*;
#(
  parameter int MAX_WORD_LENGTH = 16,
  parameter int TILE_DIM        = 8'h02,
  parameter int PE              = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [1:0]                           mode,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [MAX_WORD_LENGTH-1:0]           in_data,
  input  logic                                 flush,
  output logic [1:0]                           psc_mode,
  output logic                                 psc_start,
  input  logic                                 psc_finish,
  output logic [PE*MAX_WORD_LENGTH*TILE_DIM-1:0] psc_parallel_data,
`ifdef PSC_LOADER_PERF_EN
  output logic [15:0]                          perf_launch_count,
`endif
  output logic                                 busy
);

  localparam int N     = row_words(PE, TILE_DIM);
  localparam int ROW_W = N * MAX_WORD_LENGTH;

  psc_state_t state, state_d;
  logic       fill_ptr;
  logic       drain_ptr;
  logic       finish_take;
  logic [1:0] full;
  logic [1:0] fill_done;
  logic [1:0] bank_wr;
  logic [1:0] bank_flush;
  logic [1:0] bank_clear;
  logic [ROW_W-1:0] bank_data [2];

  // in_ready depends only on registered state, never on in_valid.
  always_comb begin
    in_ready = ~full[fill_ptr];
    for (int b = 0; b < 2; b++) begin
      bank_wr[b]    = in_valid && in_ready && (fill_ptr == 1'(b));
      bank_flush[b] = flush && (fill_ptr == 1'(b));
      bank_clear[b] = finish_take && (drain_ptr == 1'(b));
    end
  end

  for (genvar gb = 0; gb < 2; gb++) begin : g_bank
    psc_row_bank #(
      .WORD_W (MAX_WORD_LENGTH),
      .N      (N)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (bank_wr[gb]),
      .wr_data   (in_data),
      .flush     (bank_flush[gb]),
      .clear     (bank_clear[gb]),
      .data      (bank_data[gb]),
      .full      (full[gb]),
      .fill_done (fill_done[gb])
    );
  end

  // Drain FSM next state and launch pulse.
  always_comb begin
    state_d     = state;
    psc_start   = 1'b0;
    finish_take = 1'b0;
    case (state)
      IDLE: begin
        if (full[drain_ptr]) begin
          state_d   = WAIT;
          psc_start = 1'b1;
        end
      end
      WAIT: begin
        if (psc_finish) begin
          state_d     = IDLE;
          finish_take = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, bank pointers and latched converter mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fill_ptr  <= 1'b0;
      drain_ptr <= 1'b0;
      psc_mode  <= PSC_MODE_0;
    end else begin
      state <= state_d;
      if (|fill_done) begin
        fill_ptr <= ~fill_ptr;
      end
      if (finish_take) begin
        drain_ptr <= ~drain_ptr;
      end
      if (psc_start) begin
        psc_mode <= mode;
      end
    end
  end

`ifdef PSC_LOADER_PERF_EN
  // Saturating count of launches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_launch_count <= '0;
    end else if (psc_start && (perf_launch_count != 16'hFFFF)) begin
      perf_launch_count <= perf_launch_count + 16'd1;
    end
  end
`endif

  // Row presented to the converters; the drained bank is never written while full.
  always_comb begin
    psc_parallel_data = bank_data[drain_ptr];
    busy              = full[0] || full[1] || (state == WAIT);
  end

endmodule
